// File: rtl/pkt_xbar_arb.sv
// Four-source packet crossbar: per-source FIFOs drained one packet per cycle by a round-robin arbiter.
// Optional delivered-packet counter on port stat when PKT_XBAR_STAT_EN is defined.
module pkt_xbar_arb #(
    parameter int PKT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_W-1:0] tx0,
    input  logic [PKT_W-1:0] tx1,
    input  logic [PKT_W-1:0] tx2,
    input  logic [PKT_W-1:0] tx3,
    output logic [PKT_W-1:0] rx0,
    output logic [PKT_W-1:0] rx1,
    output logic [PKT_W-1:0] rx2,
    output logic [PKT_W-1:0] rx3,
    output logic             busy,
    output logic [3:0]       ovf
`ifdef PKT_XBAR_STAT_EN
    ,
    output logic [31:0]      stat
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PKT_W-1:0] w_tx      [4];
    logic [PKT_W-1:0] r_mem     [4][DEPTH];
    logic [AW-1:0]    r_wrPtr   [4];
    logic [AW-1:0]    r_rdPtr   [4];
    logic [CW-1:0]    r_count   [4];
    logic [PKT_W-1:0] r_rx      [4];
    logic [1:0]       r_rr;
    logic [3:0]       r_ovf;

    logic [3:0]       w_nonEmpty;
    logic [3:0]       w_pop;
    logic [3:0]       w_accept;
    logic [3:0]       w_drop;
    logic [1:0]       w_grant;
    logic             w_grantValid;
    logic [PKT_W-1:0] w_head;
    logic [1:0]       w_dest;

    assign w_tx[0] = tx0;
    assign w_tx[1] = tx1;
    assign w_tx[2] = tx2;
    assign w_tx[3] = tx3;

    assign rx0  = r_rx[0];
    assign rx1  = r_rx[1];
    assign rx2  = r_rx[2];
    assign rx3  = r_rx[3];
    assign busy = |w_nonEmpty;
    assign ovf  = r_ovf;

    // Arbitration only sees occupancy before this edge's push, so there is no bypass path.
    always_comb begin
        w_grant      = r_rr;
        w_grantValid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            w_nonEmpty[n] = (r_count[n] != '0);
        end
        for (int k = 3; k >= 0; k--) begin
            if (w_nonEmpty[r_rr + 2'(k)]) begin
                w_grant      = r_rr + 2'(k);
                w_grantValid = 1'b1;
            end
        end
    end

    // A full FIFO still accepts a push when it is popped on the same edge.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            w_pop[n]    = w_grantValid && (w_grant == 2'(n));
            w_accept[n] = w_tx[n][PKT_W-1] && ((r_count[n] != CW'(DEPTH)) || w_pop[n]);
            w_drop[n]   = w_tx[n][PKT_W-1] && (r_count[n] == CW'(DEPTH)) && !w_pop[n];
        end
    end

    assign w_head = r_mem[w_grant][r_rdPtr[w_grant]];
    assign w_dest = w_head[PKT_W-2 -: 2];

    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (w_accept[n]) begin
                r_mem[n][r_wrPtr[n]] <= w_tx[n];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                r_wrPtr[n] <= '0;
                r_rdPtr[n] <= '0;
                r_count[n] <= '0;
                r_rx[n]    <= '0;
            end
            r_rr  <= 2'd0;
            r_ovf <= 4'd0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (w_accept[n]) begin
                    r_wrPtr[n] <= r_wrPtr[n] + AW'(1);
                end
                if (w_pop[n]) begin
                    r_rdPtr[n] <= r_rdPtr[n] + AW'(1);
                end
                r_count[n] <= r_count[n] + CW'(w_accept[n]) - CW'(w_pop[n]);
                r_rx[n]    <= (w_grantValid && (w_dest == 2'(n))) ? w_head : '0;
            end
            if (w_grantValid) begin
                r_rr <= w_grant + 2'd1;
            end
            r_ovf <= r_ovf | w_drop;
        end
    end

`ifdef PKT_XBAR_STAT_EN
    logic [31:0] r_stat;

    assign stat = r_stat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat <= 32'd0;
        end else if (w_grantValid) begin
            r_stat <= r_stat + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pkt_xbar_arb.sv
// Directed self-checking bench for pkt_xbar_arb: latency, round-robin order, overflow, reset.
// Covers the stat counter too when PKT_XBAR_STAT_EN is defined.
module tb_pkt_xbar_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tx0 = '0;
    logic [31:0] tx1 = '0;
    logic [31:0] tx2 = '0;
    logic [31:0] tx3 = '0;
    logic [31:0] rx0;
    logic [31:0] rx1;
    logic [31:0] rx2;
    logic [31:0] rx3;
    logic        busy;
    logic [3:0]  ovf;
`ifdef PKT_XBAR_STAT_EN
    logic [31:0] stat;
`endif

    int checks   = 0;
    int failures = 0;

    pkt_xbar_arb #(.PKT_W(32), .DEPTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .tx0  (tx0),
        .tx1  (tx1),
        .tx2  (tx2),
        .tx3  (tx3),
        .rx0  (rx0),
        .rx1  (rx1),
        .rx2  (rx2),
        .rx3  (rx3),
        .busy (busy),
`ifdef PKT_XBAR_STAT_EN
        .stat (stat),
`endif
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pkt(input logic [1:0] dest, input logic [28:0] payload);
        return {1'b1, dest, payload};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] t0, input logic [31:0] t1,
                                 input logic [31:0] t2, input logic [31:0] t3);
        tx0 = t0;
        tx1 = t1;
        tx2 = t2;
        tx3 = t3;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus('0, '0, '0, '0);
        rst = 1'b1;
        #1;
        checkOutput("rst_rx", rx0 | rx1 | rx2 | rx3, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
`ifdef PKT_XBAR_STAT_EN
        checkOutput("rst_stat", stat, 32'd0);
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] got [4][8];
    int          gotCnt [4];
    int          exp3b [4][6];
    int          expCnt3b [4];

    initial begin
        // Single packet: source 1 to PU 2, two-cycle latency, one-cycle pulse.
        doReset();
        applyStimulus('0, pkt(2'd2, 29'h123), '0, '0);
        tick();
        applyStimulus('0, '0, '0, '0);
        checkOutput("t1_busy_c1", 32'(busy), 32'd1);
        checkOutput("t1_rx2_c1", rx2, 32'd0);
        tick();
        checkOutput("t1_rx2_c2", rx2, pkt(2'd2, 29'h123));
        checkOutput("t1_others_c2", rx0 | rx1 | rx3, 32'd0);
        checkOutput("t1_busy_c2", 32'(busy), 32'd0);
        tick();
        checkOutput("t1_rx2_c3", rx2, 32'd0);

        // All four sources to PU 3 in one cycle: delivered in source order from rr=0.
        doReset();
        applyStimulus(pkt(2'd3, 29'hA0), pkt(2'd3, 29'hA1), pkt(2'd3, 29'hA2), pkt(2'd3, 29'hA3));
        tick();
        applyStimulus('0, '0, '0, '0);
        checkOutput("t2_rx3_c1", rx3, 32'd0);
        checkOutput("t2_busy_c1", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t2_rx3_seq", rx3, pkt(2'd3, 29'(32'hA0 + i)));
            checkOutput("t2_others", rx0 | rx1 | rx2, 32'd0);
            checkOutput("t2_busy", 32'(busy), (i < 3) ? 32'd1 : 32'd0);
        end
        tick();
        checkOutput("t2_rx3_idle", rx3, 32'd0);

        // Source 0 alone, six back-to-back packets: no overflow, in order.
        doReset();
        for (int s = 0; s < 8; s++) begin
            if (s >= 2) begin
                checkOutput("t3_rx1", rx1, pkt(2'd1, 29'(s - 2)));
            end
            applyStimulus((s < 6) ? pkt(2'd1, 29'(s)) : 32'd0, '0, '0, '0);
            tick();
        end
        checkOutput("t3_ovf", 32'(ovf), 32'd0);
        checkOutput("t3_busy", 32'(busy), 32'd0);

        // All sources send 8 packets each to their own index; hand-traced drops per source.
        exp3b    = '{'{0, 1, 2, 3, 4, 5}, '{0, 1, 2, 3, 4, 6}, '{0, 1, 2, 3, 4, 7}, '{0, 1, 2, 3, 4, 0}};
        expCnt3b = '{6, 6, 6, 5};
        for (int n = 0; n < 4; n++) begin
            gotCnt[n] = 0;
        end
        doReset();
        for (int s = 0; s < 30; s++) begin
            if (rx0[31] && gotCnt[0] < 8) begin got[0][gotCnt[0]] = rx0; gotCnt[0]++; end
            if (rx1[31] && gotCnt[1] < 8) begin got[1][gotCnt[1]] = rx1; gotCnt[1]++; end
            if (rx2[31] && gotCnt[2] < 8) begin got[2][gotCnt[2]] = rx2; gotCnt[2]++; end
            if (rx3[31] && gotCnt[3] < 8) begin got[3][gotCnt[3]] = rx3; gotCnt[3]++; end
            if (s < 8) begin
                applyStimulus(pkt(2'd0, 29'(s)), pkt(2'd1, 29'(s)), pkt(2'd2, 29'(s)), pkt(2'd3, 29'(s)));
            end else begin
                applyStimulus('0, '0, '0, '0);
            end
            tick();
        end
        checkOutput("t3b_ovf", 32'(ovf), 32'hF);
        for (int n = 0; n < 4; n++) begin
            checkOutput("t3b_count", 32'(gotCnt[n]), 32'(expCnt3b[n]));
            for (int i = 0; i < expCnt3b[n] && i < gotCnt[n]; i++) begin
                checkOutput("t3b_order", got[n][i], pkt(2'(n), 29'(exp3b[n][i])));
            end
        end

        // Sources 0 and 2 continuously: grants alternate 0,2 and skip the idle sources.
        doReset();
        for (int k = 0; k < 15; k++) begin
            if (k >= 2 && k <= 13) begin
                checkOutput("t4_rx1", rx1, (k % 2 == 0) ? pkt(2'd1, 29'((k - 2) / 2)) : 32'd0);
                checkOutput("t4_rx3", rx3, (k % 2 == 1) ? pkt(2'd3, 29'((k - 3) / 2)) : 32'd0);
            end
            if (k < 6) begin
                applyStimulus(pkt(2'd1, 29'(k)), '0, pkt(2'd3, 29'(k)), '0);
            end else begin
                applyStimulus('0, '0, '0, '0);
            end
            tick();
        end
        checkOutput("t4_busy", 32'(busy), 32'd0);

        // Reset with three packets still queued: everything discarded, then normal latency.
        doReset();
        applyStimulus(pkt(2'd0, 29'h10), pkt(2'd0, 29'h11), pkt(2'd0, 29'h12), pkt(2'd0, 29'h13));
        tick();
        applyStimulus('0, '0, '0, '0);
        tick();
        checkOutput("t5_pre_rx0", rx0, pkt(2'd0, 29'h10));
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_rx", rx0 | rx1 | rx2 | rx3, 32'd0);
        checkOutput("t5_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            checkOutput("t5_quiet_rx", rx0 | rx1 | rx2 | rx3, 32'd0);
            checkOutput("t5_quiet_busy", 32'(busy), 32'd0);
        end
        checkOutput("t5_ovf", 32'(ovf), 32'd0);
        applyStimulus('0, '0, '0, pkt(2'd2, 29'h55));
        tick();
        applyStimulus('0, '0, '0, '0);
        checkOutput("t5_new_c1", rx2, 32'd0);
        tick();
        checkOutput("t5_new_c2", rx2, pkt(2'd2, 29'h55));

`ifdef PKT_XBAR_STAT_EN
        // 16 pushes with two drops (source 1 then source 0) leaves 14 deliveries.
        doReset();
        for (int s = 0; s < 7; s++) begin
            applyStimulus(pkt(2'd1, 29'(s)), pkt(2'd2, 29'(s)),
                          (s == 0) ? pkt(2'd3, 29'd0) : 32'd0,
                          (s == 0) ? pkt(2'd0, 29'd0) : 32'd0);
            tick();
        end
        applyStimulus('0, '0, '0, '0);
        for (int s = 0; s < 20; s++) begin
            tick();
        end
        checkOutput("stat_count", stat, 32'd14);
        checkOutput("stat_ovf", 32'(ovf), 32'h3);
        rst = 1'b1;
        #1;
        checkOutput("stat_reset", stat, 32'd0);
        tick();
        rst = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
